// File: rtl/wave_sequencer.sv
// Command-driven 8-bit waveform sequencer for the lab DAC.
// Plays square/saw/triangle/inv-saw for N periods or until abort.
module wave_sequencer #(
  parameter logic [7:0] IDLE_LEVEL = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_wave,
  input  logic [7:0] cmd_div,
  input  logic [7:0] cmd_periods,
  input  logic       abort,
  output logic [7:0] wave_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] period_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, n_state;
  logic [1:0] wave_q, n_wave;
  logic [7:0] div_q, n_div;
  logic [7:0] periods_q, n_periods;
  logic [7:0] phase, n_phase;
  logic [7:0] presc, n_presc;
  logic [7:0] n_cnt, cnt_inc;
  logic [7:0] n_sample;
  logic       n_done;

  function automatic logic [7:0] decode(
    input logic [1:0] w,
    input logic [7:0] p
  );
    logic [7:0] s;
    s = p;
    unique case (w)
      2'd0: s = p[7] ? 8'h00 : 8'hFF;
      2'd1: s = p;
      2'd2: s = p[7] ? ~{p[6:0], 1'b0}
                     : {p[6:0], 1'b0};
      2'd3: s = ~p;
    endcase
    return s;
  endfunction

  always_comb begin
    n_state   = state;
    n_wave    = wave_q;
    n_div     = div_q;
    n_periods = periods_q;
    n_phase   = phase;
    n_presc   = presc;
    n_cnt     = period_cnt;
    n_done    = 1'b0;
    cnt_inc   = (period_cnt == 8'hFF) ? 8'hFF
                                      : period_cnt + 8'd1;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          n_wave    = cmd_wave;
          n_div     = cmd_div;
          n_periods = cmd_periods;
          n_phase   = '0;
          n_presc   = '0;
          n_cnt     = '0;
          n_state   = RUN;
        end
      end
      RUN: begin
        if (presc == div_q) begin
          n_presc = '0;
          n_phase = phase + 8'd1;
          if (phase == 8'hFF) begin
            n_cnt = cnt_inc;
            if (periods_q != 8'd0 &&
                cnt_inc == periods_q) begin
              n_state = IDLE;
              n_done  = 1'b1;
            end
          end
        end else begin
          n_presc = presc + 8'd1;
        end
        // abort overrides completion but keeps the count
        if (abort) begin
          n_state = IDLE;
          n_phase = '0;
          n_presc = '0;
          n_done  = 1'b0;
        end
      end
    endcase
    n_sample = (n_state == RUN) ? decode(n_wave, n_phase)
                                : IDLE_LEVEL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wave_q     <= '0;
      div_q      <= '0;
      periods_q  <= '0;
      phase      <= '0;
      presc      <= '0;
      period_cnt <= '0;
      wave_out   <= IDLE_LEVEL;
      done       <= 1'b0;
    end else begin
      state      <= n_state;
      wave_q     <= n_wave;
      div_q      <= n_div;
      periods_q  <= n_periods;
      phase      <= n_phase;
      presc      <= n_presc;
      period_cnt <= n_cnt;
      wave_out   <= n_sample;
      done       <= n_done;
    end
  end

  assign busy      = (state == RUN);
  assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer.
// Reference samples come from an independent phase model.
module tb_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_wave;
  logic [7:0] cmd_div;
  logic [7:0] cmd_periods;
  logic       abort;
  logic [7:0] wave_out;
  logic       busy;
  logic       done;
  logic [7:0] period_cnt;

  int checks = 0;
  int failures = 0;

  wave_sequencer dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wave(cmd_wave),
    .cmd_div(cmd_div),
    .cmd_periods(cmd_periods),
    .abort(abort),
    .wave_out(wave_out),
    .busy(busy),
    .done(done),
    .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_sample(
    input int w, input int p);
    case (w)
      0: return (p < 128) ? 8'hFF : 8'h00;
      1: return 8'(p);
      2: return (p < 128) ? 8'(2 * p)
                          : 8'(255 - 2 * (p - 128));
      default: return 8'(255 - p);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int w, input int d,
                       input int p);
    cmd_wave    = 2'(w);
    cmd_div     = 8'(d);
    cmd_periods = 8'(p);
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  // edges k0..k0+n-1 after accept: playing, no done
  task automatic run_check(input string tag, input int w,
                           input int d, input int k0,
                           input int n);
    int bad;
    int ph;
    bad = 0;
    for (int k = k0; k < k0 + n; k++) begin
      tick();
      ph = (k / (d + 1)) % 256;
      if (wave_out !== ref_sample(w, ph) ||
          busy !== 1'b1 || done !== 1'b0)
        bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_wave = '0;
    cmd_div = '0;
    cmd_periods = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wave", 32'(wave_out), 32'h80);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_wave", 32'(wave_out), 32'h80);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_cnt", 32'(period_cnt), 32'd0);

    // square, div 0, 2 periods
    issue(0, 0, 2);
    chk("sq_first", 32'(wave_out), 32'hFF);
    chk("sq_busy", 32'(busy), 32'd1);
    chk("sq_ready", 32'(cmd_ready), 32'd0);
    run_check("sq_run", 0, 0, 1, 511);
    tick();
    chk("sq_done", 32'(done), 32'd1);
    chk("sq_cnt", 32'(period_cnt), 32'd2);
    chk("sq_idle", 32'(wave_out), 32'h80);
    chk("sq_busy0", 32'(busy), 32'd0);
    tick();
    chk("sq_done1", 32'(done), 32'd0);

    // sawtooth, div 3, 1 period
    issue(1, 3, 1);
    chk("saw_first", 32'(wave_out), 32'h00);
    run_check("saw_run", 1, 3, 1, 1023);
    tick();
    chk("saw_done", 32'(done), 32'd1);
    chk("saw_cnt", 32'(period_cnt), 32'd1);
    tick();

    // triangle continuous, abort after 600
    issue(2, 0, 0);
    run_check("tri_run", 2, 0, 1, 600);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tri_busy", 32'(busy), 32'd0);
    chk("tri_wave", 32'(wave_out), 32'h80);
    chk("tri_done", 32'(done), 32'd0);
    chk("tri_cnt", 32'(period_cnt), 32'd2);
    tick();
    chk("tri_done1", 32'(done), 32'd0);

    // cmd_valid held through RUN
    cmd_wave = 2'd3;
    cmd_div = 8'd0;
    cmd_periods = 8'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_wave = 2'd0;
    run_check("held_run", 3, 0, 1, 255);
    tick();
    chk("held_done", 32'(done), 32'd1);
    chk("held_ready", 32'(cmd_ready), 32'd1);
    chk("held_busy0", 32'(busy), 32'd0);
    tick();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_wave", 32'(wave_out), 32'hFF);
    chk("b2b_cnt", 32'(period_cnt), 32'd0);
    chk("b2b_done", 32'(done), 32'd0);
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b2b_abort", 32'(busy), 32'd0);

    // abort on final completion edge
    issue(1, 0, 1);
    run_check("af_run", 1, 0, 1, 255);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("af_done", 32'(done), 32'd0);
    chk("af_busy", 32'(busy), 32'd0);
    chk("af_cnt", 32'(period_cnt), 32'd1);
    chk("af_wave", 32'(wave_out), 32'h80);
    tick();
    chk("af_done1", 32'(done), 32'd0);

    // abort in IDLE does not block accept
    abort = 1'b1;
    cmd_wave = 2'd0;
    cmd_div = 8'd0;
    cmd_periods = 8'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("ia_busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    chk("ia_abort", 32'(busy), 32'd0);

    // reset mid-run
    issue(0, 0, 3);
    run_check("rr_run", 0, 0, 1, 300);
    rst = 1'b0;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_ready", 32'(cmd_ready), 32'd1);
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_wave", 32'(wave_out), 32'h80);
    chk("rr_cnt", 32'(period_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("rr_done1", 32'(done), 32'd0);
    chk("rr_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
